// File: rtl/pool_pkg.sv
// Shared constants and reader state encoding for the pooled-feature buffer
// (the writer block reuses the same geometry constants).
package pool_pkg;
    localparam int POOL_CH     = 3;
    localparam int POOL_ROWS   = 3;
    localparam int POOL_COLS   = 3;
    localparam int POOL_DW     = 8;
    localparam int POOL_NELEM  = POOL_CH * POOL_ROWS * POOL_COLS;
    localparam int POOL_SNAP_W = POOL_NELEM * POOL_DW;
    localparam int POOL_IW     = 2;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } pool_rd_state_e;
endpackage

// File: rtl/pool_idx_cnt.sv
// Nested ch/r/c wrap counter; ORDER=0 runs c fastest then r then ch,
// ORDER=1 runs ch fastest then c then r.
module pool_idx_cnt
    import pool_pkg::*;
#(
    parameter int CH    = POOL_CH,
    parameter int ROWS  = POOL_ROWS,
    parameter int COLS  = POOL_COLS,
    parameter int ORDER = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               adv_i,
    output logic [POOL_IW-1:0] ch_o,
    output logic [POOL_IW-1:0] r_o,
    output logic [POOL_IW-1:0] c_o,
    output logic               is_last_o
);
    localparam logic [POOL_IW-1:0] CH_MAX = POOL_IW'(CH - 1);
    localparam logic [POOL_IW-1:0] R_MAX  = POOL_IW'(ROWS - 1);
    localparam logic [POOL_IW-1:0] C_MAX  = POOL_IW'(COLS - 1);

    logic [POOL_IW-1:0] ch_q, ch_d, r_q, r_d, c_q, c_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ch_q <= '0;
            r_q  <= '0;
            c_q  <= '0;
        end else begin
            ch_q <= ch_d;
            r_q  <= r_d;
            c_q  <= c_d;
        end
    end

    always_comb begin
        ch_d = ch_q;
        r_d  = r_q;
        c_d  = c_q;
        if (clr_i) begin
            ch_d = '0;
            r_d  = '0;
            c_d  = '0;
        end else if (adv_i) begin
            if (ORDER == 0) begin
                if (c_q == C_MAX) begin
                    c_d = '0;
                    if (r_q == R_MAX) begin
                        r_d  = '0;
                        ch_d = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end else begin
                if (ch_q == CH_MAX) begin
                    ch_d = '0;
                    if (c_q == C_MAX) begin
                        c_d = '0;
                        r_d = (r_q == R_MAX) ? '0 : r_q + 1'b1;
                    end else begin
                        c_d = c_q + 1'b1;
                    end
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
        end
    end

    assign ch_o      = ch_q;
    assign r_o       = r_q;
    assign c_o       = c_q;
    assign is_last_o = (ch_q == CH_MAX) && (r_q == R_MAX) && (c_q == C_MAX);
endmodule

// File: rtl/pool_lin_reader.sv
// Snapshots the flat pooled vector on start and streams it one element per
// beat. Handshake: a beat transfers on any cycle with out_vld & out_rdy; out_vld
// is a pure function of state and the beat fields hold while out_rdy is low.
module pool_lin_reader
    import pool_pkg::*;
#(
    parameter int CH    = POOL_CH,
    parameter int ROWS  = POOL_ROWS,
    parameter int COLS  = POOL_COLS,
    parameter int DW    = POOL_DW,
    parameter int ORDER = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CH*ROWS*COLS*DW-1:0]  pool_lin,
    output logic                        busy,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [DW-1:0]               out_data,
    output logic [1:0]                  out_ch,
    output logic [1:0]                  out_r,
    output logic [1:0]                  out_c,
    output logic                        out_last,
    output logic                        done,
    output pool_rd_state_e              dbg_state
);
    localparam int NELEM = CH * ROWS * COLS;

    pool_rd_state_e          state_q, state_d;
    logic [NELEM*DW-1:0]     snap_q, snap_d;
    logic                    done_q, done_d;
    logic [POOL_IW-1:0]      idx_ch, idx_r, idx_c;
    logic                    idx_last;
    logic                    streaming, cnt_clr, cnt_adv;
    logic [31:0]             addr;
    logic [DW-1:0]           sel_byte;

    assign streaming = (state_q == RD_STREAM);
    assign cnt_clr   = (state_q == RD_IDLE) && start;
    assign cnt_adv   = streaming && out_rdy;

    pool_idx_cnt #(
        .CH(CH), .ROWS(ROWS), .COLS(COLS), .ORDER(ORDER)
    ) u_idx (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (cnt_clr),
        .adv_i     (cnt_adv),
        .ch_o      (idx_ch),
        .r_o       (idx_r),
        .c_o       (idx_c),
        .is_last_o (idx_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RD_IDLE;
            snap_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        done_d  = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (start) begin
                    state_d = RD_STREAM;
                    snap_d  = pool_lin;
                end
            end
            RD_STREAM: begin
                if (out_rdy && idx_last) begin
                    state_d = RD_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Full-width address so no geometry can alias two elements.
    assign addr = 32'(idx_ch) * 32'(ROWS * COLS) + 32'(idx_r) * 32'(COLS) + 32'(idx_c);

    always_comb begin
        sel_byte = '0;
        for (int k = 0; k < NELEM; k++) begin
            if (addr == 32'(k)) sel_byte = snap_q[k*DW +: DW];
        end
    end

    assign busy      = streaming;
    assign out_vld   = streaming;
    assign out_data  = streaming ? sel_byte : '0;
    assign out_ch    = streaming ? idx_ch : '0;
    assign out_r     = streaming ? idx_r : '0;
    assign out_c     = streaming ? idx_c : '0;
    assign out_last  = streaming && idx_last;
    assign done      = done_q;
    assign dbg_state = state_q;
endmodule

// File: doc/pool_lin_reader.md
Name: pool_lin_reader

Overview:
- Read-side counterpart of the pooling result buffer.
- On `start`, snapshots the flat CH x ROWS x COLS x DW pooled feature vector (`pool_lin`, channel-major layout, byte address = ch*ROWS*COLS + r*COLS + c).
- Streams the snapshot one byte per beat over a valid/ready interface to the downstream fully-connected / classifier stage.
- Emits coordinates, a last-beat flag and a done pulse.

Parameters:
- CH, 3, number of channels
- ROWS, 3, pooled rows per channel
- COLS, 3, pooled columns per row
- DW, 8, element width in bits
- ORDER, 0, 0 = channel-major (c fastest, then r, then ch); 1 = pixel-major (ch fastest, then c, then r)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request to snapshot `pool_lin` and begin streaming
- pool_lin  in  CH*ROWS*COLS*DW  flat pooled vector, byte k at [k*DW +: DW]
- busy  out  1  high while a frame is being streamed
- out_vld  out  1  out_data is valid
- out_rdy  in  1  downstream accepts a beat
- out_data  out  DW  current element
- out_ch  out  2  channel index of current element
- out_r  out  2  row index of current element
- out_c  out  2  column index of current element
- out_last  out  1  current beat is the final element of the frame
- done  out  1  one-cycle pulse after the final transfer

Behaviour:
- Interface (already decided): one clock, `clk`. Reset `rst` is synchronous and active-high. All flops update only on `posedge clk`.
- Reset values: every output 0, snapshot register 0, counters 0, state IDLE.
- States:
  - IDLE: busy=0, out_vld=0.
  - STREAM: busy=1, out_vld=1.
- IDLE -> STREAM: `start`=1 in cycle T.
  - `pool_lin` is captured into the internal snapshot at the T edge.
  - Counters cleared.
  - In T+1: out_vld=1, out_data = element 0, busy=1.
- Transfer occurs in any cycle with out_vld & out_rdy; the counters then advance at that edge.
- While out_vld=1 and out_rdy=0, out_data, out_ch/r/c and out_last are held stable.
- Beat order:
  - ORDER=0 visits byte addresses 0,1,...,26.
  - ORDER=1 visits (r,c,ch) with ch fastest: addresses 0,9,18,1,10,19,...,26.
- Address arithmetic: addr = ch*ROWS*COLS + r*COLS + c, computed at full width (no truncation). Mux selects snapshot[addr*DW +: DW].
- out_last=1 exactly when the counters point at the final element (ch=CH-1, r=ROWS-1, c=COLS-1 for either order).
- Final transfer (out_last & out_rdy) at cycle N:
  - State returns to IDLE at the N edge.
  - In N+1: busy=0, out_vld=0, done=1 for exactly one cycle.
- Minimum frame with out_rdy held high: start at T, beats T+1..T+27, done at T+28.
- start while busy (including the final-transfer cycle): ignored; no re-snapshot, no counter disturbance.
- start in the cycle done=1: accepted (state is IDLE); next frame begins the following cycle.
- `pool_lin` changes after the snapshot: no effect on the in-flight frame.
- rst asserted mid-frame: synchronous abort; next cycle all outputs 0, IDLE; no done pulse.
- out_vld never depends combinationally on out_rdy.
- When out_vld=0: out_data, out_ch/r/c and out_last are driven 0.

Decomposition:
- Shared package `pool_pkg`:
  - POOL_CH, POOL_ROWS, POOL_COLS, POOL_DW constants.
  - POOL_NELEM = CH*ROWS*COLS.
  - Snapshot width constant.
  - Reader state encoding (IDLE, STREAM).
  - The writer block reuses the same constants.
- One sub-module, `pool_idx_cnt`:
  - Nested ch/r/c wrap counter with `clr` and `adv` inputs and an ORDER parameter.
  - Outputs the indices and an is_last flag.
  - The top holds the FSM, snapshot register and byte mux.

Test Plan:
- Sequential data, ORDER=0, out_rdy=1: byte k = k+1, start at cycle 0 -> out_data 1..27 on cycles 1..27; (ch,r,c) = (0,0,0)..(2,2,2); out_last only on value 27; done=1 on cycle 28 only.
- Same data, ORDER=1 -> out_data 1,10,19,2,11,20,3,12,21,...,9,18,27; out_last with value 27 at (2,2,2).
- Backpressure: out_rdy pattern 1,0,0,1,0,1... -> each value held across stall cycles; exactly 27 transfers, no duplicates or skips; done one cycle after the last accepted beat.
- Snapshot isolation and start-while-busy: overwrite `pool_lin` with 8'hFF and pulse start at beat 5 -> stream still 1..27; the FF frame streams only if start is re-pulsed on or after the done cycle.
- Back-to-back: start asserted in the done cycle -> second frame's beat 0 appears the next cycle; busy low for exactly that one cycle.
- Reset mid-frame: rst=1 at beat 10 -> next cycle busy=0, out_vld=0, outputs 0, no done; a new start restarts from element 0 (value 1).
